// File: rtl/modport_ctrl_if.sv
// ---------------------------------------------------------------------------
// modport_ctrl_if
// Bundles every non-clock, non-reset signal of the capture/readout
// controller. This includes the command inputs from the trigger stage, the
// sample stream, the sample-memory handshake and the transmitter handshake.
//
// Signals (directions seen from the controller, i.e. the slave modport):
//   set_cnt_i  in   1  load count registers from cmd_i (IDLE only)
//   cmd_i      in  32  [31:16] delay field D, [15:0] read field R
//   run_i      in   1  trigger fired
//   stb_i      in   1  sample strobe, smpls_i valid
//   smpls_i    in  32  sample word
//   mem_i      in  32  memory read data, valid the cycle after mem_read_o
//   tx_rdy_i   in   1  transmitter can accept a word
//   mem_read_o out  1  memory read request pulse
//   mem_wrt_o  out  1  memory write enable
//   mem_o      out 32  memory write data
//   tx_stb_o   out  1  tx_o valid pulse
//   tx_o       out 32  word to transmit
//
// The slave modport is taken by the controller. The master modport is
// taken by whatever drives it (surrounding core or testbench).
// ---------------------------------------------------------------------------
interface modport_ctrl_if;
  logic        set_cnt_i;
  logic [31:0] cmd_i;
  logic        run_i;
  logic        stb_i;
  logic [31:0] smpls_i;
  logic [31:0] mem_i;
  logic        tx_rdy_i;
  logic        mem_read_o;
  logic        mem_wrt_o;
  logic [31:0] mem_o;
  logic        tx_stb_o;
  logic [31:0] tx_o;

  modport slave (
    input  set_cnt_i, cmd_i, run_i, stb_i, smpls_i, mem_i, tx_rdy_i,
    output mem_read_o, mem_wrt_o, mem_o, tx_stb_o, tx_o
  );

  modport master (
    output set_cnt_i, cmd_i, run_i, stb_i, smpls_i, mem_i, tx_rdy_i,
    input  mem_read_o, mem_wrt_o, mem_o, tx_stb_o, tx_o
  );
endinterface

// File: rtl/modport_ctrl.sv
// ---------------------------------------------------------------------------
// modport_ctrl
// Capture/readout controller of the logic analyzer core.
//
// While armed, every strobed sample word is written into sample memory. After
// the trigger, a programmed number of post-trigger strobes (4*D) is still
// captured. Then 4*(R+1) words are read back from memory and handed to the
// UART transmitter, one per handshake.
//
// Ports:
//   clk_i   in  1  system clock, rising edge
//   rst_in  in  1  synchronous reset, active high
//   bus         modport_ctrl_if.slave (command, sample, memory and tx signals)
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// ---------------------------------------------------------------------------
module modport_ctrl (
  input logic           clk_i,
  input logic           rst_in,
  modport_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    READ,
    RDWAIT,
    RDLATCH
  } state_e;

  state_e      state_q;
  logic [15:0] rdCnt_q;
  logic [15:0] dlyCnt_q;
  logic [17:0] cnt_q;
  logic        memRead_q;
  logic        memWrt_q;
  logic [31:0] memData_q;
  logic        txStb_q;
  logic [31:0] txData_q;

  logic [17:0] rdTarget;
  logic [17:0] dlyTarget;
  logic [17:0] cntPlus1;

  // Targets are kept in 18 bits, matching the counter width. For R = 0xFFFF
  // the read target wraps to 0. The counter wraps to 0 on the same word, so
  // the equality test still ends the readout after 4*65536 words.
  assign rdTarget  = ({2'b00, rdCnt_q} + 18'd1) << 2;
  assign dlyTarget = {dlyCnt_q, 2'b00};
  assign cntPlus1  = cnt_q + 18'd1;

  assign bus.mem_read_o = memRead_q;
  assign bus.mem_wrt_o  = memWrt_q;
  assign bus.mem_o      = memData_q;
  assign bus.tx_stb_o   = txStb_q;
  assign bus.tx_o       = txData_q;

  // Single registered FSM. The pulse outputs (write enable, read request,
  // tx strobe) default low every cycle, and each state raises the ones it
  // needs. Write data and tx data hold their last value between pulses.
  //
  // The shared counter counts post-trigger strobes in DELAY and delivered
  // words in the READ group. It is cleared whenever control crosses between
  // the capture side (IDLE/DELAY) and the readout side.
  //
  // In READ, a new word is not requested while tx_stb_o is still high, so
  // the transmitter always sees the previous strobe drop first.
  always_ff @(posedge clk_i) begin
    if (rst_in) begin
      state_q   <= IDLE;
      rdCnt_q   <= '0;
      dlyCnt_q  <= '0;
      cnt_q     <= '0;
      memRead_q <= 1'b0;
      memWrt_q  <= 1'b0;
      memData_q <= '0;
      txStb_q   <= 1'b0;
      txData_q  <= '0;
    end else begin
      memRead_q <= 1'b0;
      memWrt_q  <= 1'b0;
      txStb_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.set_cnt_i) begin
            rdCnt_q  <= bus.cmd_i[15:0];
            dlyCnt_q <= bus.cmd_i[31:16];
          end
          if (bus.stb_i) begin
            memWrt_q  <= 1'b1;
            memData_q <= bus.smpls_i;
          end
          if (bus.run_i) begin
            state_q <= DELAY;
            cnt_q   <= '0;
          end
        end
        DELAY: begin
          if (bus.stb_i) begin
            memWrt_q  <= 1'b1;
            memData_q <= bus.smpls_i;
          end
          if (cnt_q == dlyTarget) begin
            state_q <= READ;
            cnt_q   <= '0;
          end else if (bus.stb_i) begin
            cnt_q <= cntPlus1;
          end
        end
        READ: begin
          if (bus.tx_rdy_i && !txStb_q) begin
            memRead_q <= 1'b1;
            state_q   <= RDWAIT;
          end
        end
        RDWAIT: begin
          state_q <= RDLATCH;
        end
        RDLATCH: begin
          txData_q <= bus.mem_i;
          txStb_q  <= 1'b1;
          if (cntPlus1 == rdTarget) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            state_q <= READ;
            cnt_q   <= cntPlus1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modport_ctrl.sv
// ---------------------------------------------------------------------------
// tb_modport_ctrl
// Randomized, scoreboard-based bench for modport_ctrl.
//
// The stimulus side issues capture transactions: load counts, trigger, feed
// post-trigger strobes, then let the readout run.
//
// Every write the model expects is queued together with the cycle in which it
// must appear. The bench-side memory returns random words and queues each one
// as an expected transmit two cycles after the read request.
//
// A negedge monitor compares the DUT's write and transmit outputs against
// those queues every cycle. It also checks that each read request follows a
// cycle with tx_rdy_i high and tx_stb_o low.
// ---------------------------------------------------------------------------
module tb_modport_ctrl;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic clk_i;
  logic rst_in;
  modport_ctrl_if bus();

  modport_ctrl dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int   vecCount = 0;
  int   missCount = 0;
  int   cycleNo = 0;
  int   readsSeen = 0;
  int   txSeen = 0;
  int   firstReadCycle = -1;
  bit   started = 0;
  bit   rdyPrev = 0;
  bit   stbPrev = 0;
  exp_t writeQ[$];
  exp_t txQ[$];

  // Free-running clock and a cycle index used to timestamp expectations.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleNo++;

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNo, got, exp);
    end
  endtask

  // Drives one cycle of inputs. In capture-open cycles, a strobe is
  // scoreboarded as a write due next cycle. A reset cycle discards
  // everything still in flight, since the DUT aborts it.
  task automatic applyStimulus(input bit rst, input bit setCnt, input logic [31:0] cmd,
                               input bit run, input bit stb, input logic [31:0] smpl,
                               input bit rdy, input bit open);
    exp_t e;
    rst_in        = rst;
    bus.set_cnt_i = setCnt;
    bus.cmd_i     = cmd;
    bus.run_i     = run;
    bus.stb_i     = stb;
    bus.smpls_i   = smpl;
    bus.tx_rdy_i  = rdy;
    if (stb && open && !rst) begin
      e.due  = cycleNo + 1;
      e.data = smpl;
      writeQ.push_back(e);
    end
    if (rst) begin
      #2;
      txQ.delete();
      writeQ.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_mem_read", bus.mem_read_o, 0);
    checkOutput("rst_mem_wrt", bus.mem_wrt_o, 0);
    checkOutput("rst_mem_o", bus.mem_o, 0);
    checkOutput("rst_tx_stb", bus.tx_stb_o, 0);
    checkOutput("rst_tx_o", bus.tx_o, 0);
  endtask

  // Bench-side sample memory. A read request seen in one cycle is answered
  // with a fresh random word in the next cycle. That word must be
  // transmitted one cycle later still. Outside read responses mem_i carries
  // noise, so a DUT that samples at the wrong time picks up a wrong word.
  always @(posedge clk_i) begin
    logic wasRead;
    logic wasRst;
    exp_t e;
    wasRead = bus.mem_read_o;
    wasRst  = rst_in;
    #1;
    if (wasRead === 1'b1 && wasRst === 1'b0) begin
      e.due  = cycleNo + 1;
      e.data = $urandom;
      bus.mem_i = e.data;
      txQ.push_back(e);
    end else begin
      bus.mem_i = $urandom;
    end
  end

  // Scoreboard monitor: every cycle, the write and transmit strobes must
  // match whether an expectation falls due now. When one does, the data
  // must match as well.
  always @(negedge clk_i) begin
    bit expW;
    bit expT;
    if (started) begin
      expW = (writeQ.size() > 0) && (writeQ[0].due == cycleNo);
      checkOutput("mem_wrt", bus.mem_wrt_o, expW);
      if (expW) begin
        checkOutput("mem_o", bus.mem_o, writeQ[0].data);
        void'(writeQ.pop_front());
      end
      expT = (txQ.size() > 0) && (txQ[0].due == cycleNo);
      checkOutput("tx_stb", bus.tx_stb_o, expT);
      if (expT) begin
        checkOutput("tx_o", bus.tx_o, txQ[0].data);
        void'(txQ.pop_front());
      end
      if (bus.tx_stb_o === 1'b1) txSeen++;
      if (bus.mem_read_o === 1'b1) begin
        readsSeen++;
        if (firstReadCycle < 0) firstReadCycle = cycleNo;
        checkOutput("read_handshake", {30'd0, rdyPrev, stbPrev}, 2);
      end
      rdyPrev = bus.tx_rdy_i;
      stbPrev = bus.tx_stb_o;
    end
  end

  // One capture: load counts together with the trigger, feed 4*D
  // post-trigger strobes (plus a possibly strobed exit cycle), then drive
  // the readout. rdyMode 0 keeps tx_rdy_i high after holdOff cycles;
  // rdyMode 1 randomizes it. abortAfter > 0 resets after that many words.
  // Inputs that must be ignored (set_cnt_i, run_i, stb_i) are toggled
  // randomly outside IDLE.
  task automatic runCapture(input logic [15:0] d, input logic [15:0] r, input int rdyMode,
                            input int holdOff, input int abortAfter);
    int  target;
    int  n;
    int  guard;
    int  exitCycle;
    int  readsAtReset;
    bit  exitNow;
    bit  stb;
    bit  rdy;
    bit  quiet;
    target = 4 * (int'(r) + 1);
    readsSeen = 0;
    txSeen = 0;
    firstReadCycle = -1;
    applyStimulus(0, 1, {d, r}, 1, rb(), $urandom, rb(), 1);
    n = 0;
    guard = 0;
    exitCycle = 0;
    forever begin
      exitNow = (n == 4 * int'(d));
      stb = (guard > 40) ? 1'b1 : rb();
      exitCycle = cycleNo;
      applyStimulus(0, rb(), $urandom, rb(), stb, $urandom, rb(), 1);
      guard++;
      if (exitNow) break;
      if (stb) n++;
    end
    guard = 0;
    while (txSeen < target && (abortAfter == 0 || txSeen < abortAfter) && guard < 3000) begin
      if (holdOff > 0 && guard == holdOff) checkOutput("hold_no_read", readsSeen, 0);
      rdy = (guard < holdOff) ? 1'b0 : ((rdyMode == 1) ? rb() : 1'b1);
      quiet = (txSeen >= target - 1);
      applyStimulus(0, quiet ? 1'b0 : rb(), $urandom, quiet ? 1'b0 : rb(),
                    quiet ? 1'b0 : rb(), $urandom, rdy, 0);
      guard++;
    end
    if (guard >= 3000) checkOutput("readout_timeout", txSeen, target);
    if (abortAfter > 0) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 1, 0);
      checkResetOutputs();
      readsAtReset = readsSeen;
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("abort_no_read", readsSeen, readsAtReset);
      checkOutput("abort_words", txSeen, abortAfter);
    end else begin
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("word_count", txSeen, target);
      checkOutput("read_count", readsSeen, target);
      if (rdyMode == 0) checkOutput("first_read_cycle", firstReadCycle, exitCycle + 2 + holdOff);
    end
  endtask

  initial begin
    rst_in        = 1'b1;
    bus.set_cnt_i = 1'b0;
    bus.cmd_i     = '0;
    bus.run_i     = 1'b0;
    bus.stb_i     = 1'b0;
    bus.smpls_i   = '0;
    bus.mem_i     = '0;
    bus.tx_rdy_i  = 1'b0;
    @(posedge clk_i);
    #1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    started = 1;
    $display("[TB] reset released, starting stimulus");
    checkResetOutputs();

    applyStimulus(0, 0, 0, 0, 1, 32'hA5A5_0001, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    runCapture(16'd1, 16'd0, 0, 0, 0);
    runCapture(16'd0, 16'd0, 0, 20, 0);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) applyStimulus(0, 0, 0, 0, rb(), $urandom, rb(), 1);
      runCapture(16'($urandom_range(0, 3)), 16'($urandom_range(0, 2)), 1, 0, 0);
    end

    runCapture(16'd0, 16'd1, 0, 0, 2);
    runCapture(16'd2, 16'd1, 1, 0, 0);

    for (int j = 0; j < 3; j++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
